// File: rtl/fft_cmd_sequencer_pkg.sv
// rtl/fft_cmd_sequencer_pkg.sv - shared types, defaults and helpers for the FFT command sequencer
package fft_cmd_sequencer_pkg;

  localparam int FSQ_SEQ_W        = 3;
  localparam int FSQ_MAX_PASSES   = 4;
  localparam int FSQ_PASS_W       = 2;
  localparam int FSQ_RESET_CYCLES = 4;
  localparam int FSQ_START_WAIT   = 15;
  localparam int FSQ_RUN_TIMEOUT  = 4095;

  typedef enum logic [2:0] {
    FSQ_IDLE      = 3'd0,
    FSQ_RST       = 3'd1,
    FSQ_START     = 3'd2,
    FSQ_WAIT_BUSY = 3'd3,
    FSQ_RUN       = 3'd4,
    FSQ_NEXT      = 3'd5,
    FSQ_DONE      = 3'd6,
    FSQ_ERR       = 3'd7
  } fsq_state_t;

  // Command word is {fft_reset, fft_start, sequence}; bit positions follow the sequence width.
  function automatic int cmd_reset_bit(input int seq_w);
    return seq_w + 1;
  endfunction

  function automatic int cmd_start_bit(input int seq_w);
    return seq_w;
  endfunction

  // The watchdog load is registered alongside the state change, so it lands one cycle
  // into the new state; the preset is therefore two less than the cycles to spend there.
  function automatic int wd_preset_cycles(input int cycles);
    return cycles - 2;
  endfunction

endpackage

// File: rtl/fft_cmd_sequencer_watchdog.sv
// rtl/fft_cmd_sequencer_watchdog.sv - loadable saturating down-counter with clear and expiry flag
module fft_cmd_sequencer_watchdog #(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] preset,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  // Load takes priority, then clear; otherwise count down and stick at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= preset;
    end else if (clear) begin
      count <= '0;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  // A pending load masks expiry so a freshly entered state never sees a stale zero.
  assign expired = !load && (count == '0);

endmodule

// File: rtl/fft_cmd_sequencer.sv
// rtl/fft_cmd_sequencer.sv - per-pass reset/start/wait sequencer driving the 1-D FFT command bus
module fft_cmd_sequencer
  import fft_cmd_sequencer_pkg::*;
#(
  parameter int SEQ_W        = FSQ_SEQ_W,
  parameter int MAX_PASSES   = FSQ_MAX_PASSES,
  parameter int PASS_W       = FSQ_PASS_W,
  parameter int RESET_CYCLES = FSQ_RESET_CYCLES,
  parameter int START_WAIT   = FSQ_START_WAIT,
  parameter int RUN_TIMEOUT  = FSQ_RUN_TIMEOUT
) (
  input  logic                        i_fft_base_clock,
  input  logic                        i_fft_reset_n,
  input  logic                        i_req,
  input  logic                        i_inverse,
  input  logic [PASS_W:0]             i_pass_count,
  input  logic [SEQ_W*MAX_PASSES-1:0] i_seq_list,
  input  logic                        i_fft_busy,
  output logic [SEQ_W+1:0]            command,
  output logic                        controlIFFT,
  output logic                        o_ack,
  output logic                        o_done,
  output logic                        o_error,
  output logic                        o_busy,
  output logic [PASS_W-1:0]           o_pass_idx
);

  localparam int CMD_W         = SEQ_W + 2;
  localparam int CMD_RESET_BIT = cmd_reset_bit(SEQ_W);
  localparam int CMD_START_BIT = cmd_start_bit(SEQ_W);
  localparam int CNT_W         = $clog2(RUN_TIMEOUT + 1);

  localparam logic [CNT_W-1:0]  RST_PRESET  = CNT_W'(wd_preset_cycles(RESET_CYCLES));
  localparam logic [CNT_W-1:0]  WAIT_PRESET = CNT_W'(wd_preset_cycles(START_WAIT));
  localparam logic [CNT_W-1:0]  RUN_PRESET  = CNT_W'(wd_preset_cycles(RUN_TIMEOUT));
  localparam logic [PASS_W:0]   MAX_CNT     = (PASS_W + 1)'(MAX_PASSES);

  function automatic logic [CMD_W-1:0] cmd_word(input logic rst, input logic start,
                                                input logic [SEQ_W-1:0] seq);
    logic [CMD_W-1:0] w;
    w                = '0;
    w[CMD_RESET_BIT] = rst;
    w[CMD_START_BIT] = start;
    w[SEQ_W-1:0]     = seq;
    return w;
  endfunction

  fsq_state_t                  state;
  logic [PASS_W:0]             pass_cnt_q;
  logic [SEQ_W*MAX_PASSES-1:0] seq_q;
  logic                        wd_load;
  logic [CNT_W-1:0]            wd_preset;
  logic                        wd_clear;
  logic                        wd_expired;
  logic [PASS_W-1:0]           nxt_idx;
  logic [SEQ_W-1:0]            cur_seq;
  logic [SEQ_W-1:0]            nxt_seq;
  logic                        last_pass;

  assign nxt_idx   = o_pass_idx + 1'b1;
  assign cur_seq   = seq_q[o_pass_idx * SEQ_W +: SEQ_W];
  assign nxt_seq   = seq_q[nxt_idx * SEQ_W +: SEQ_W];
  assign last_pass = (({1'b0, o_pass_idx}) + 1'b1) == pass_cnt_q;
  assign wd_clear  = (state == FSQ_IDLE);

  fft_cmd_sequencer_watchdog #(
    .CNT_W(CNT_W)
  ) u_watchdog (
    .clk    (i_fft_base_clock),
    .rst_n  (i_fft_reset_n),
    .clear  (wd_clear),
    .load   (wd_load),
    .preset (wd_preset),
    .expired(wd_expired)
  );

  // Sequencer FSM: every output is set on the edge that enters the state it belongs to.
  always_ff @(posedge i_fft_base_clock or negedge i_fft_reset_n) begin
    if (!i_fft_reset_n) begin
      state       <= FSQ_IDLE;
      command     <= cmd_word(1'b1, 1'b0, '0);
      controlIFFT <= 1'b0;
      o_ack       <= 1'b0;
      o_done      <= 1'b0;
      o_error     <= 1'b0;
      o_busy      <= 1'b0;
      o_pass_idx  <= '0;
      pass_cnt_q  <= '0;
      seq_q       <= '0;
      wd_load     <= 1'b0;
      wd_preset   <= '0;
    end else begin
      o_ack   <= 1'b0;
      o_done  <= 1'b0;
      wd_load <= 1'b0;
      case (state)
        FSQ_IDLE: begin
          command     <= '0;
          controlIFFT <= 1'b0;
          o_busy      <= 1'b0;
          if (i_req) begin
            o_ack       <= 1'b1;
            o_error     <= 1'b0;
            o_busy      <= 1'b1;
            o_pass_idx  <= '0;
            pass_cnt_q  <= i_pass_count;
            seq_q       <= i_seq_list;
            controlIFFT <= i_inverse;
            if (i_pass_count == '0) begin
              state <= FSQ_DONE;
            end else if (i_pass_count > MAX_CNT) begin
              state   <= FSQ_ERR;
              o_error <= 1'b1;
              command <= cmd_word(1'b1, 1'b0, '0);
            end else begin
              state     <= FSQ_RST;
              command   <= cmd_word(1'b1, 1'b0, i_seq_list[SEQ_W-1:0]);
              wd_load   <= 1'b1;
              wd_preset <= RST_PRESET;
            end
          end
        end
        FSQ_RST: begin
          if (wd_expired) begin
            state   <= FSQ_START;
            command <= cmd_word(1'b0, 1'b1, cur_seq);
          end
        end
        FSQ_START: begin
          state     <= FSQ_WAIT_BUSY;
          wd_load   <= 1'b1;
          wd_preset <= WAIT_PRESET;
        end
        FSQ_WAIT_BUSY: begin
          if (i_fft_busy) begin
            state     <= FSQ_RUN;
            command   <= cmd_word(1'b0, 1'b0, cur_seq);
            wd_load   <= 1'b1;
            wd_preset <= RUN_PRESET;
          end else if (wd_expired) begin
            state   <= FSQ_ERR;
            o_error <= 1'b1;
            command <= cmd_word(1'b1, 1'b0, '0);
          end
        end
        FSQ_RUN: begin
          if (!i_fft_busy) begin
            state <= FSQ_NEXT;
          end else if (wd_expired) begin
            state   <= FSQ_ERR;
            o_error <= 1'b1;
            command <= cmd_word(1'b1, 1'b0, '0);
          end
        end
        FSQ_NEXT: begin
          if (last_pass) begin
            state   <= FSQ_DONE;
            command <= '0;
          end else begin
            state      <= FSQ_RST;
            o_pass_idx <= nxt_idx;
            command    <= cmd_word(1'b1, 1'b0, nxt_seq);
            wd_load    <= 1'b1;
            wd_preset  <= RST_PRESET;
          end
        end
        FSQ_DONE: begin
          state       <= FSQ_IDLE;
          o_done      <= 1'b1;
          o_busy      <= 1'b0;
          controlIFFT <= 1'b0;
          command     <= '0;
        end
        FSQ_ERR: begin
          o_error <= 1'b1;
          if (!i_req) begin
            state       <= FSQ_IDLE;
            o_busy      <= 1'b0;
            controlIFFT <= 1'b0;
            command     <= '0;
          end
        end
        default: begin
          state <= FSQ_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_cmd_sequencer.sv
// tb/tb_fft_cmd_sequencer.sv - directed table-driven bench for the FFT command sequencer
module tb_fft_cmd_sequencer;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        inverse;
  logic [2:0]  pass_count;
  logic [11:0] seq_list;
  logic        fft_busy;
  logic [4:0]  command;
  logic        ctrl_ifft;
  logic        ack;
  logic        done;
  logic        error;
  logic        busy_o;
  logic [1:0]  pass_idx;

  int checks = 0;
  int errors = 0;

  fft_cmd_sequencer dut (
    .i_fft_base_clock(clk),
    .i_fft_reset_n   (rst_n),
    .i_req           (req),
    .i_inverse       (inverse),
    .i_pass_count    (pass_count),
    .i_seq_list      (seq_list),
    .i_fft_busy      (fft_busy),
    .command         (command),
    .controlIFFT     (ctrl_ifft),
    .o_ack           (ack),
    .o_done          (done),
    .o_error         (error),
    .o_busy          (busy_o),
    .o_pass_idx      (pass_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        inv;
    logic [2:0]  cnt;
    logic [11:0] seqs;
    int          delay;       // cycles from first start sample to busy rise; -1 = never
    int          len;         // cycles busy stays high; -1 = stuck
    int          exp_done;
    int          exp_err;
    int          exp_err_ack;
    int          exp_passes;
    logic [11:0] exp_seen;
    logic [7:0]  exp_idx;
    int          exp_start_len;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int n, input vec_t v);
    int cyc, dones, acks, passes, rst_len, rst_bad, st_len, st_max, inv_bad, timer, left, err_ack;
    logic prev_rst, prev_st, finished;
    logic [11:0] seen;
    logic [7:0]  idxs;
    cyc = 0; dones = 0; acks = 0; passes = 0; rst_len = 0; rst_bad = 0;
    st_len = 0; st_max = 0; inv_bad = 0; timer = 0; left = 0; err_ack = -1;
    prev_rst = 1'b0; prev_st = 1'b0; finished = 1'b0; seen = '0; idxs = '0;
    @(negedge clk);
    req = 1'b1; inverse = v.inv; pass_count = v.cnt; seq_list = v.seqs; fft_busy = 1'b0;
    while (!finished && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      if (ack) begin
        acks++;
        err_ack = int'(error);
        req = 1'b0; inverse = ~v.inv; pass_count = 3'd1; seq_list = ~v.seqs;
      end
      if (busy_o && ctrl_ifft !== v.inv) inv_bad++;
      if (done) dones++;
      if (command[4] && busy_o && !error) begin
        if (!prev_rst) begin
          if (passes < 4) begin
            seen[passes*3 +: 3] = command[2:0];
            idxs[passes*2 +: 2] = pass_idx;
          end
          rst_len = 0;
        end
        rst_len++;
        prev_rst = 1'b1;
      end else begin
        if (prev_rst) begin
          passes++;
          if (rst_len != 4) rst_bad++;
        end
        prev_rst = 1'b0;
      end
      if (left > 0) begin
        left--;
        if (left == 0) fft_busy = 1'b0;
      end
      if (timer > 0) begin
        timer--;
        if (timer == 0) begin
          fft_busy = 1'b1;
          left = v.len;
        end
      end
      if (command[3]) begin
        if (!prev_st) begin
          st_len = 0;
          if (v.delay > 0) timer = v.delay;
        end
        st_len++;
        prev_st = 1'b1;
      end else begin
        if (prev_st && st_len > st_max) st_max = st_len;
        prev_st = 1'b0;
      end
      if (done || (error && !busy_o)) finished = 1'b1;
    end
    fft_busy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
    check($sformatf("v%0d_finished", n), 32'(finished), 32'd1);
    check($sformatf("v%0d_acks", n), acks, 1);
    check($sformatf("v%0d_err_at_ack", n), err_ack, v.exp_err_ack);
    check($sformatf("v%0d_done_pulses", n), dones, v.exp_done);
    check($sformatf("v%0d_error_end", n), 32'(error), v.exp_err);
    check($sformatf("v%0d_passes", n), passes, v.exp_passes);
    check($sformatf("v%0d_seq_trace", n), 32'(seen), 32'(v.exp_seen));
    check($sformatf("v%0d_idx_trace", n), 32'(idxs), 32'(v.exp_idx));
    check($sformatf("v%0d_start_len", n), st_max, v.exp_start_len);
    check($sformatf("v%0d_rst_len_bad", n), rst_bad, 0);
    check($sformatf("v%0d_ifft_bad", n), inv_bad, 0);
  endtask

  initial begin
    int   got_ack, hold, run_cycles, reached;
    logic saw_start;

    //          inv  cnt   seqs          dly len done err eack pas seen    idx    stlen
    vecs[0] = '{1'b0, 3'd1, 12'h005,       3, 20,  1,  0,  0,  1, 12'h005, 8'h00, 4};
    vecs[1] = '{1'b1, 3'd2, 12'h011,       3, 20,  1,  0,  0,  2, 12'h011, 8'h04, 4};
    vecs[2] = '{1'b0, 3'd4, 12'hF9C,       1,  1,  1,  0,  0,  4, 12'hF9C, 8'hE4, 2};
    vecs[3] = '{1'b0, 3'd1, 12'h006,      -1,  0,  0,  1,  0,  1, 12'h006, 8'h00, 16};
    vecs[4] = '{1'b0, 3'd1, 12'h003,       2, -1,  0,  1,  0,  1, 12'h003, 8'h00, 3};
    vecs[5] = '{1'b1, 3'd0, 12'h000,       3, 20,  1,  0,  0,  0, 12'h000, 8'h00, 0};
    vecs[6] = '{1'b0, 3'd5, 12'hFFF,       3, 20,  0,  1,  1,  0, 12'h000, 8'h00, 0};
    vecs[7] = '{1'b1, 3'd3, 12'h053,       5,  2,  1,  0,  0,  3, 12'h053, 8'h24, 6};

    rst_n = 1'b0; req = 1'b0; inverse = 1'b0; pass_count = '0; seq_list = '0; fft_busy = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_cmd", 32'(command), 32'h10);
    check("reset_flags", 32'({ctrl_ifft, ack, done, error, busy_o, pass_idx}), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_cmd", 32'(command), 32'h00);
    check("idle_flags", 32'({ctrl_ifft, ack, done, error, busy_o, pass_idx}), 32'h0);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // pass_count = 0: ack in one cycle, done in the next, no start ever
    @(negedge clk);
    req = 1'b1; pass_count = 3'd0; inverse = 1'b0;
    got_ack = 0; saw_start = 1'b0;
    for (int c = 0; c < 10 && got_ack == 0; c++) begin
      @(negedge clk);
      if (command[3]) saw_start = 1'b1;
      if (ack) got_ack = 1;
    end
    req = 1'b0;
    check("zero_ack_seen", got_ack, 1);
    check("zero_done_not_with_ack", 32'(done), 32'd0);
    @(negedge clk);
    if (command[3]) saw_start = 1'b1;
    check("zero_done_next", 32'({done, saw_start}), 32'b10);

    // asynchronous reset in the middle of pass 1's run phase
    repeat (2) @(negedge clk);
    req = 1'b1; pass_count = 3'd2; seq_list = 12'h00A; inverse = 1'b1;
    hold = 0; run_cycles = 0; reached = 0;
    for (int c = 0; c < 300 && reached == 0; c++) begin
      @(negedge clk);
      if (ack) req = 1'b0;
      if (command[3]) begin
        fft_busy = 1'b1;
        hold = (pass_idx == 2'd0) ? 5 : 1000;
      end else if (fft_busy) begin
        if (hold > 0) hold--;
        if (hold == 0) fft_busy = 1'b0;
        if (pass_idx == 2'd1 && command[4:3] == 2'b00) begin
          run_cycles++;
          if (run_cycles >= 3) reached = 1;
        end
      end
    end
    check("midrun_reached", reached, 1);
    rst_n = 1'b0;
    #1;
    check("midrun_reset_cmd", 32'(command), 32'h10);
    check("midrun_reset_flags", 32'({ctrl_ifft, ack, done, error, busy_o, pass_idx}), 32'h0);
    fft_busy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_cmd", 32'(command), 32'h00);
    check("post_reset_flags", 32'({ctrl_ifft, ack, done, error, busy_o, pass_idx}), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
